control32_mc: RTL

//  Multi-cycle successor of the single-cycle MIPS main decoder. Same opcode/funct decode, now

---
 rtl/control32_mc.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/control32_mc.sv
// Multi-cycle MIPS main control: IF/ID/EX/MEM/IOW/WB sequencer with an I/O wait-state
// handshake, a bounded I/O wait and a parametrised I/O address window.
module control32_mc #(
  parameter int                     ADDR_HIGH_W = 22,
  parameter logic [ADDR_HIGH_W-1:0] IO_HIGH     = 22'h3FFFFF,
  parameter int                     IO_TIMEOUT  = 15,
  parameter int                     TMO_W       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic [5:0]             func,
  input  logic [ADDR_HIGH_W-1:0] alu_result_high,
  input  logic                   zero,
  input  logic                   io_ready,
  output logic                   ir_write,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   jmp,
  output logic                   jal,
  output logic                   jr,
  output logic                   branch,
  output logic                   nbranch,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   alu_src,
  output logic                   i_format,
  output logic                   sftmd,
  output logic [1:0]             alu_op,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   io_read,
  output logic                   io_write,
  output logic                   memorio_to_reg,
  output logic                   io_timeout,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_IOW = 3'd5
  } state_t;

  state_t           cur;
  logic [TMO_W-1:0] count;

  logic is_r, is_jr, is_i, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_sft, known, is_io, tmo_hit, levels_on;

  always_comb begin
    is_r    = (opcode == 6'b000000);
    is_jr   = is_r && (func == 6'b001000);
    is_i    = (opcode[5:3] == 3'b001);
    is_lw   = (opcode == 6'b100011);
    is_sw   = (opcode == 6'b101011);
    is_beq  = (opcode == 6'b000100);
    is_bne  = (opcode == 6'b000101);
    is_j    = (opcode == 6'b000010);
    is_jal  = (opcode == 6'b000011);
    is_sft  = is_r && (func inside {6'b000000, 6'b000010, 6'b000011,
                                    6'b000100, 6'b000110, 6'b000111});
    known   = is_r | is_i | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
    is_io   = (alu_result_high == IO_HIGH);
    tmo_hit = (count == TMO_W'(IO_TIMEOUT));
  end

  // Sequencer; the IOW counter holds the number of the current wait cycle (1-based).
  always_ff @(posedge clock) begin
    if (reset) begin
      cur   <= S_IF;
      count <= '0;
    end else begin
      case (cur)
        S_IF: cur <= S_ID;
        S_ID: begin
          if (is_j || is_jal || is_jr || !known) cur <= S_IF;
          else                                   cur <= S_EX;
        end
        S_EX: begin
          if (is_lw || is_sw)     cur <= S_MEM;
          else if (is_r || is_i)  cur <= S_WB;
          else                    cur <= S_IF;
        end
        S_MEM: begin
          if (is_io && !io_ready) begin
            cur   <= S_IOW;
            count <= TMO_W'(1);
          end else if (is_lw) begin
            cur <= S_WB;
          end else begin
            cur <= S_IF;
          end
        end
        S_IOW: begin
          if (io_ready || tmo_hit) begin
            count <= '0;
            cur   <= is_lw ? S_WB : S_IF;
          end else begin
            count <= count + TMO_W'(1);
          end
        end
        S_WB: cur <= S_IF;
        default: begin
          cur   <= S_IF;
          count <= '0;
        end
      endcase
    end
  end

  // Outputs follow the current state and the live inputs of that cycle (zero in EX,
  // io_ready in MEM/IOW), so they are decoded here rather than registered.
  always_comb begin
    ir_write       = 1'b0;
    pc_inc         = 1'b0;
    pc_load        = 1'b0;
    jmp            = 1'b0;
    jal            = 1'b0;
    jr             = 1'b0;
    branch         = 1'b0;
    nbranch        = 1'b0;
    reg_write      = 1'b0;
    reg_dst        = 1'b0;
    alu_src        = 1'b0;
    i_format       = 1'b0;
    sftmd          = 1'b0;
    alu_op         = 2'b00;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    io_read        = 1'b0;
    io_write       = 1'b0;
    memorio_to_reg = 1'b0;
    io_timeout     = 1'b0;
    state          = 3'd0;
    levels_on      = 1'b0;

    if (!reset) begin
      state     = cur;
      levels_on = (cur == S_EX) || (cur == S_MEM) || (cur == S_IOW) || (cur == S_WB);
      if (levels_on) begin
        reg_dst  = is_r;
        alu_src  = is_i | is_lw | is_sw;
        i_format = is_i;
        sftmd    = is_sft;
        alu_op   = {is_r | is_i, is_beq | is_bne};
      end

      case (cur)
        S_IF: begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
        end
        S_ID: begin
          if (is_j) begin
            jmp     = 1'b1;
            pc_load = 1'b1;
          end else if (is_jal) begin
            jal       = 1'b1;
            pc_load   = 1'b1;
            reg_write = 1'b1;
          end else if (is_jr) begin
            jr      = 1'b1;
            pc_load = 1'b1;
          end
        end
        S_EX: begin
          if (is_beq) begin
            branch  = 1'b1;
            pc_load = zero;
          end else if (is_bne) begin
            nbranch = 1'b1;
            pc_load = ~zero;
          end
        end
        S_MEM: begin
          if (is_io) begin
            io_read  = is_lw;
            io_write = is_sw;
          end else begin
            mem_read  = is_lw;
            mem_write = is_sw;
          end
        end
        S_IOW: begin
          io_read    = is_lw;
          io_write   = is_sw;
          io_timeout = tmo_hit && !io_ready;
        end
        S_WB: begin
          reg_write      = 1'b1;
          memorio_to_reg = is_lw;
        end
        default: ;
      endcase
    end
  end

endmodule
